// File: rtl/seq_shifter_pkg.sv
// shifter_pkg: op encodings (shared with ALU decode) and FSM states for seq_shifter
package shifter_pkg;
   localparam int OP_W = 3;
   typedef enum logic [OP_W-1:0] {
      OP_NONE = 3'b000,
      OP_LSL  = 3'b001,
      OP_LSR  = 3'b010,
      OP_ASR  = 3'b011,
      OP_ROL  = 3'b100,
      OP_ROR  = 3'b101
   } shift_op_e;
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
endpackage

// File: rtl/seq_shifter_shift_step.sv
// shift_step: combinational shift/rotate of val_i by k bits; ROL/ROR only with SEQ_SHIFTER_ROTATE_EN
module shift_step import shifter_pkg::*; #(
   parameter int WIDTH = 16,
   localparam int AMT_W = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] val_i,
   input  logic [OP_W-1:0]  op,
   input  logic [AMT_W-1:0] k,
   output logic [WIDTH-1:0] val_o,
   output logic             carry_o
);
   always_comb begin
      val_o = val_i;
      carry_o = 1'b0;
      case (op)
         OP_LSL: {carry_o, val_o} = {1'b0, val_i} << k;
         OP_LSR: {val_o, carry_o} = {val_i, 1'b0} >> k;
         OP_ASR: {val_o, carry_o} = $signed({val_i, 1'b0}) >>> k;
`ifdef SEQ_SHIFTER_ROTATE_EN
         OP_ROL: begin
            val_o = (val_i << k) | (val_i >> (WIDTH - int'(k)));
            carry_o = (k != '0) & val_o[0];
         end
         OP_ROR: begin
            val_o = (val_i >> k) | (val_i << (WIDTH - int'(k)));
            carry_o = (k != '0) & val_o[WIDTH-1];
         end
`endif
         default: ;
      endcase
   end
endmodule

// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle shifter/rotator, up to STEP bits per clock, valid/ready on both sides.
// ROL/ROR are implemented only when SEQ_SHIFTER_ROTATE_EN is defined.
module seq_shifter import shifter_pkg::*; #(
   parameter int WIDTH = 16,
   parameter int STEP = 1,
   localparam int AMT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] shift_in,
   input  logic [OP_W-1:0]  shift_op,
   input  logic [AMT_W-1:0] shift_amt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] shift_out,
   output logic             carry_out,
   output logic             zero
);
   localparam logic [AMT_W:0] STEP_W = (AMT_W+1)'(STEP);
   state_e state_q, state_d;
   logic [WIDTH-1:0] val_q, val_d, step_val;
   logic [OP_W-1:0] op_q, op_d;
   logic [AMT_W-1:0] rem_q, rem_d, k;
   logic carry_q, carry_d, step_carry, in_ready_q, in_ready_d, out_valid_q, out_valid_d;
   assign k = ({1'b0, rem_q} < STEP_W) ? rem_q : STEP_W[AMT_W-1:0];
   shift_step #(.WIDTH(WIDTH)) u_step (
      .val_i(val_q), .op(op_q), .k(k), .val_o(step_val), .carry_o(step_carry)
   );
   always_comb begin
      state_d = state_q;
      val_d = val_q;
      op_d = op_q;
      rem_d = rem_q;
      carry_d = carry_q;
      case (state_q)
         IDLE: if (in_valid) begin
            state_d = SHIFT;
            val_d = shift_in;
            op_d = shift_op;
            rem_d = shift_amt;
            carry_d = 1'b0;
         end
         SHIFT: begin
            val_d = step_val;
            carry_d = step_carry;
            rem_d = rem_q - k;
            state_d = (rem_q == k) ? DONE : SHIFT;
         end
         default: state_d = out_ready ? IDLE : DONE;
      endcase
      in_ready_d = state_d == IDLE;
      out_valid_d = state_d == DONE;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         val_q <= '0;
         op_q <= '0;
         rem_q <= '0;
         carry_q <= 1'b0;
         in_ready_q <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         val_q <= val_d;
         op_q <= op_d;
         rem_q <= rem_d;
         carry_q <= carry_d;
         in_ready_q <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end
   assign in_ready = in_ready_q;
   assign out_valid = out_valid_q;
   assign shift_out = val_q;
   assign carry_out = carry_q;
   assign zero = out_valid_q & ~|val_q;
endmodule

// File: tb/tb_seq_shifter.sv
// tb_seq_shifter: table-driven scoreboard bench for seq_shifter (STEP=1 and STEP=4 instances)
module tb_seq_shifter;
   import shifter_pkg::*;
`ifdef SEQ_SHIFTER_ROTATE_EN
   localparam bit ROT = 1'b1;
`else
   localparam bit ROT = 1'b0;
`endif
   typedef struct {logic [15:0] out; logic c; int lat;} exp_t;
   typedef struct {int d; logic [2:0] op; logic [3:0] amt; logic [15:0] in; logic [15:0] out; logic c; int lat;} vec_t;
   logic clk = 1'b0, rst_n = 1'b0;
   logic [1:0] in_valid, in_ready, out_valid, out_ready, carry_out, zero;
   logic [1:0][15:0] shift_in, shift_out;
   logic [1:0][2:0] shift_op;
   logic [1:0][3:0] shift_amt;
   exp_t sb[$];
   vec_t tbl[$];
   int n_chk = 0, n_fail = 0;
   always #5 clk = ~clk;
   seq_shifter #(.WIDTH(16), .STEP(1)) u_s1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .shift_in(shift_in[0]), .shift_op(shift_op[0]), .shift_amt(shift_amt[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]), .shift_out(shift_out[0]),
      .carry_out(carry_out[0]), .zero(zero[0])
   );
   seq_shifter #(.WIDTH(16), .STEP(4)) u_s4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .shift_in(shift_in[1]), .shift_op(shift_op[1]), .shift_amt(shift_amt[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]), .shift_out(shift_out[1]),
      .carry_out(carry_out[1]), .zero(zero[1])
   );
   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic issue(int d, logic [2:0] op, logic [3:0] amt, logic [15:0] v, exp_t e);
      @(negedge clk);
      shift_in[d] = v;
      shift_op[d] = op;
      shift_amt[d] = amt;
      in_valid[d] = 1'b1;
      check("in_ready_before_accept", {31'b0, in_ready[d]}, 1);
      @(posedge clk);
      sb.push_back(e);
      #1;
      in_valid[d] = 1'b0;
      shift_in[d] = ~v;
      shift_op[d] = OP_LSL;
      shift_amt[d] = amt + 4'd3;
   endtask
   task automatic collect(int d, string name);
      int cyc = 0;
      exp_t e;
      while (!out_valid[d] && cyc < 40) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      if (!out_valid[d]) begin
         n_chk++;
         n_fail++;
         $display("FAIL %s timeout: out_valid not seen within 40 cycles", name);
      end
      e = sb.pop_front();
      check({name, "_latency"}, cyc, e.lat);
      check({name, "_out"}, {16'b0, shift_out[d]}, {16'b0, e.out});
      check({name, "_carry"}, {31'b0, carry_out[d]}, {31'b0, e.c});
      check({name, "_zero"}, {31'b0, zero[d]}, {31'b0, e.out == 16'h0});
   endtask
   task automatic ack(int d, string name);
      out_ready[d] = 1'b1;
      @(posedge clk);
      #1;
      out_ready[d] = 1'b0;
      check({name, "_ack_out_valid"}, {31'b0, out_valid[d]}, 0);
      check({name, "_ack_in_ready"}, {31'b0, in_ready[d]}, 1);
   endtask
   initial begin
      bit ever;
      in_valid = '0;
      out_ready = '0;
      shift_in = '0;
      shift_op = '0;
      shift_amt = '0;
      tbl.push_back('{0, OP_LSL,  4'd1, 16'hF0CF, 16'hE19E, 1'b1, 1});
      tbl.push_back('{0, OP_LSR,  4'd4, 16'hF0CF, 16'h0F0C, 1'b1, 4});
      tbl.push_back('{0, OP_ASR,  4'd4, 16'hF0CF, 16'hFF0C, 1'b1, 4});
      tbl.push_back('{0, OP_ASR,  4'd4, 16'h2273, 16'h0227, 1'b0, 4});
      tbl.push_back('{0, OP_NONE, 4'd5, 16'h1234, 16'h1234, 1'b0, 5});
      tbl.push_back('{0, 3'b110,  4'd2, 16'hABCD, 16'hABCD, 1'b0, 2});
      tbl.push_back('{0, OP_ROL,  4'd1, 16'h8001, ROT ? 16'h0003 : 16'h8001, ROT, 1});
      tbl.push_back('{0, OP_ROR,  4'd1, 16'h8001, ROT ? 16'hC000 : 16'h8001, ROT, 1});
      tbl.push_back('{1, OP_ROL,  4'd4, 16'h1234, ROT ? 16'h2341 : 16'h1234, ROT, 1});
      tbl.push_back('{1, OP_ROR,  4'd4, 16'h1234, ROT ? 16'h4123 : 16'h1234, 1'b0, 1});
      tbl.push_back('{1, OP_LSL,  4'd15, 16'h0001, 16'h8000, 1'b0, 4});
      tbl.push_back('{1, OP_LSR,  4'd0, 16'h1234, 16'h1234, 1'b0, 1});
      tbl.push_back('{1, OP_LSL,  4'd8, 16'h00FF, 16'hFF00, 1'b0, 2});
      tbl.push_back('{1, OP_LSR,  4'd8, 16'h00FF, 16'h0000, 1'b1, 2});
      tbl.push_back('{1, OP_ASR,  4'd7, 16'h8000, 16'hFF00, 1'b0, 2});
      tbl.push_back('{1, OP_LSL,  4'd5, 16'h8421, 16'h8420, 1'b0, 2});
      repeat (2) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         check("rst_in_ready", {31'b0, in_ready[d]}, 1);
         check("rst_out_valid", {31'b0, out_valid[d]}, 0);
         check("rst_shift_out", {16'b0, shift_out[d]}, 0);
         check("rst_carry", {31'b0, carry_out[d]}, 0);
         check("rst_zero", {31'b0, zero[d]}, 0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      foreach (tbl[i]) begin
         issue(tbl[i].d, tbl[i].op, tbl[i].amt, tbl[i].in, '{tbl[i].out, tbl[i].c, tbl[i].lat});
         collect(tbl[i].d, $sformatf("vec%0d", i));
         ack(tbl[i].d, $sformatf("vec%0d", i));
      end
      issue(0, OP_LSL, 4'd1, 16'h0003, '{16'h0006, 1'b0, 1});
      collect(0, "bp");
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid[0] = 1'b1;
         shift_in[0] = 16'hFFFF;
         @(posedge clk);
         #1;
         check("bp_hold_out", {16'b0, shift_out[0]}, 32'h0006);
         check("bp_hold_valid", {31'b0, out_valid[0]}, 1);
         check("bp_hold_in_ready", {31'b0, in_ready[0]}, 0);
      end
      out_ready[0] = 1'b1;
      @(posedge clk);
      #1;
      in_valid[0] = 1'b0;
      out_ready[0] = 1'b0;
      check("bp_release_valid", {31'b0, out_valid[0]}, 0);
      check("bp_no_accept_on_release", {31'b0, in_ready[0]}, 1);
      @(posedge clk);
      #1;
      check("bp_idle_stays", {31'b0, in_ready[0]}, 1);
      @(negedge clk);
      shift_in[0] = 16'h8000;
      shift_op[0] = OP_LSR;
      shift_amt[0] = 4'd10;
      in_valid[0] = 1'b1;
      @(posedge clk);
      #1;
      in_valid[0] = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("abort_in_ready", {31'b0, in_ready[0]}, 1);
      check("abort_out_valid", {31'b0, out_valid[0]}, 0);
      check("abort_shift_out", {16'b0, shift_out[0]}, 0);
      check("abort_carry", {31'b0, carry_out[0]}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      ever = 1'b0;
      repeat (15) begin
         @(posedge clk);
         #1;
         ever |= out_valid[0];
      end
      check("abort_no_result", {31'b0, ever}, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
